joy_cursor: RTL and testbench



---
 rtl/joy_cursor.sv | 191 +++++++++++++++++++
 tb/tb_joy_cursor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_cursor.sv
// joy_cursor: debounced buttons to bounded X/Y cursor with auto-repeat
// and a frame-coherent position copy latched on frame_tick.
module joy_cursor #(
  parameter int X_WIDTH         = 10,
  parameter int Y_WIDTH         = 10,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int X_INIT          = 320,
  parameter int Y_INIT          = 240,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1250000,
  parameter int WRAP            = 0,
  parameter int DIAGONAL        = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  input  logic               frame_tick,
  output logic [X_WIDTH-1:0] joy_x,
  output logic [Y_WIDTH-1:0] joy_y,
  output logic [X_WIDTH-1:0] player_x,
  output logic [Y_WIDTH-1:0] player_y,
  output logic               moved,
  output logic [3:0]         btn
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE - 1);

  localparam logic [X_WIDTH:0] XMN = (X_WIDTH+1)'(X_MIN);
  localparam logic [X_WIDTH:0] XMX = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0] XST = (X_WIDTH+1)'(STEP);
  localparam logic [Y_WIDTH:0] YMN = (Y_WIDTH+1)'(Y_MIN);
  localparam logic [Y_WIDTH:0] YMX = (Y_WIDTH+1)'(Y_MAX);
  localparam logic [Y_WIDTH:0] YST = (Y_WIDTH+1)'(STEP);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [3:0]    raw, s1, s2;
  logic [DW-1:0] cnt [4];
  logic [3:0]    dir, dir_q;
  logic          xl, xr, yu, yd;
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          step, chg;
  logic [X_WIDTH:0] px, nx;
  logic [Y_WIDTH:0] py, ny;

  assign raw = {left, right, up, down};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      btn <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == btn[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          btn[i] <= ~btn[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // opposing buttons cancel before priority is applied
  assign xl = btn[3] & ~btn[2];
  assign xr = btn[2] & ~btn[3];
  assign yu = btn[1] & ~btn[0];
  assign yd = btn[0] & ~btn[1];

  always_comb begin
    dir = '0;
    if (DIAGONAL != 0) dir = {xl, xr, yu, yd};
    else if (xl)       dir = 4'b1000;
    else if (xr)       dir = 4'b0100;
    else if (yu)       dir = 4'b0010;
    else if (yd)       dir = 4'b0001;
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    step    = 1'b0;
    if (dir == '0) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          step    = 1'b1;
          state_n = DELAY;
          timer_n = T_DELAY;
        end
        DELAY, REPEAT: begin
          if (dir != dir_q) begin
            step    = 1'b1;
            state_n = DELAY;
            timer_n = T_DELAY;
          end else if (timer == '0) begin
            step    = 1'b1;
            state_n = REPEAT;
            timer_n = T_RATE;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign px = {1'b0, joy_x};
  assign py = {1'b0, joy_y};

  // bound tests are rearranged so nothing underflows at W+1 bits
  always_comb begin
    nx = px;
    if (step && dir[3]) begin
      if (px < XMN + XST)
        nx = (WRAP != 0) ? px + XMX + 1'b1 - XMN - XST : XMN;
      else
        nx = px - XST;
    end else if (step && dir[2]) begin
      if (px + XST > XMX)
        nx = (WRAP != 0) ? px + XST - XMX - 1'b1 + XMN : XMX;
      else
        nx = px + XST;
    end
  end

  always_comb begin
    ny = py;
    if (step && dir[1]) begin
      if (py < YMN + YST)
        ny = (WRAP != 0) ? py + YMX + 1'b1 - YMN - YST : YMN;
      else
        ny = py - YST;
    end else if (step && dir[0]) begin
      if (py + YST > YMX)
        ny = (WRAP != 0) ? py + YST - YMX - 1'b1 + YMN : YMX;
      else
        ny = py + YST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      dir_q    <= '0;
      joy_x    <= X_WIDTH'(X_INIT);
      joy_y    <= Y_WIDTH'(Y_INIT);
      player_x <= X_WIDTH'(X_INIT);
      player_y <= Y_WIDTH'(Y_INIT);
      chg      <= 1'b0;
      moved    <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      dir_q <= dir;
      joy_x <= nx[X_WIDTH-1:0];
      joy_y <= ny[Y_WIDTH-1:0];
      chg   <= (nx != px) || (ny != py);
      moved <= chg;
      if (frame_tick) begin
        player_x <= joy_x;
        player_y <= joy_y;
      end
    end
  end

endmodule

// File: tb/tb_joy_cursor.sv
// Directed self-checking bench for joy_cursor: four instances cover
// default, clamp at X_MAX, wrap at X_MAX and diagonal configurations.
module tb_joy_cursor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] raw [4];
  logic [9:0] jx [4];
  logic [9:0] jy [4];
  logic [9:0] px [4];
  logic [9:0] py [4];
  logic       mv [4];
  logic [3:0] bt [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  joy_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8))
  u_def (
    .clk(clk), .reset(reset),
    .left(raw[0][3]), .right(raw[0][2]), .up(raw[0][1]), .down(raw[0][0]),
    .frame_tick(frame_tick),
    .joy_x(jx[0]), .joy_y(jy[0]), .player_x(px[0]), .player_y(py[0]),
    .moved(mv[0]), .btn(bt[0])
  );

  joy_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8),
               .X_INIT(639), .WRAP(0))
  u_clamp (
    .clk(clk), .reset(reset),
    .left(raw[1][3]), .right(raw[1][2]), .up(raw[1][1]), .down(raw[1][0]),
    .frame_tick(frame_tick),
    .joy_x(jx[1]), .joy_y(jy[1]), .player_x(px[1]), .player_y(py[1]),
    .moved(mv[1]), .btn(bt[1])
  );

  joy_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8),
               .X_INIT(639), .WRAP(1))
  u_wrap (
    .clk(clk), .reset(reset),
    .left(raw[2][3]), .right(raw[2][2]), .up(raw[2][1]), .down(raw[2][0]),
    .frame_tick(frame_tick),
    .joy_x(jx[2]), .joy_y(jy[2]), .player_x(px[2]), .player_y(py[2]),
    .moved(mv[2]), .btn(bt[2])
  );

  joy_cursor #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8),
               .DIAGONAL(1))
  u_diag (
    .clk(clk), .reset(reset),
    .left(raw[3][3]), .right(raw[3][2]), .up(raw[3][1]), .down(raw[3][0]),
    .frame_tick(frame_tick),
    .joy_x(jx[3]), .joy_y(jy[3]), .player_x(px[3]), .player_y(py[3]),
    .moved(mv[3]), .btn(bt[3])
  );

  task automatic do_reset();
    for (int i = 0; i < 4; i++) raw[i] = 4'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (jx[0] !== 10'd320) begin
      n_fail++; $display("FAIL reset_joy_x: got %0d expected 320", jx[0]);
    end
    n_chk++;
    if (px[0] !== 10'd320) begin
      n_fail++; $display("FAIL reset_player_x: got %0d expected 320", px[0]);
    end
    n_chk++;
    if (jy[0] !== 10'd240) begin
      n_fail++; $display("FAIL reset_joy_y: got %0d expected 240", jy[0]);
    end
    n_chk++;
    if (py[0] !== 10'd240) begin
      n_fail++; $display("FAIL reset_player_y: got %0d expected 240", py[0]);
    end
    n_chk++;
    if (bt[0] !== 4'b0) begin
      n_fail++; $display("FAIL reset_btn: got %b expected 0000", bt[0]);
    end
    n_chk++;
    if (mv[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_moved: got %b expected 0", mv[0]);
    end
    n_chk++;
    if (jx[1] !== 10'd639) begin
      n_fail++; $display("FAIL reset_clamp_x: got %0d expected 639", jx[1]);
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    do_reset();
    raw[0] = 4'b1000;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (bt[0] != 4'b0) seen++;
      if (i == 3) raw[0] = 4'b0;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL glitch_btn: got %0d btn cycles expected 0", seen);
    end
    n_chk++;
    if (jx[0] !== 10'd320) begin
      n_fail++; $display("FAIL glitch_x: got %0d expected 320", jx[0]);
    end
  endtask

  task automatic test_single_press();
    int t_btn = 0;
    int t_pos = 0;
    int t_mv = 0;
    int n_mv = 0;
    do_reset();
    raw[0] = 4'b1000;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bt[0][3] && t_btn == 0) t_btn = i;
      if (jx[0] != 10'd320 && t_pos == 0) t_pos = i;
      if (mv[0]) begin
        n_mv++;
        if (t_mv == 0) t_mv = i;
      end
      if (i == 10) raw[0] = 4'b0;
    end
    n_chk++;
    if (t_btn !== 6) begin
      n_fail++; $display("FAIL press_btn_latency: got %0d expected 6", t_btn);
    end
    n_chk++;
    if (t_pos !== 7) begin
      n_fail++; $display("FAIL press_pos_latency: got %0d expected 7", t_pos);
    end
    n_chk++;
    if (t_mv !== 8 || n_mv !== 1) begin
      n_fail++;
      $display("FAIL press_moved: got cycle %0d count %0d expected cycle 8 count 1",
               t_mv, n_mv);
    end
    n_chk++;
    if (jx[0] !== 10'd319) begin
      n_fail++; $display("FAIL press_x: got %0d expected 319", jx[0]);
    end
  endtask

  task automatic test_auto_repeat();
    int st [8];
    int exp_t [6] = '{7, 27, 35, 43, 51, 59};
    int n = 0;
    logic [9:0] prev;
    do_reset();
    prev = jx[0];
    raw[0] = 4'b0100;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      if (jx[0] != prev) begin
        if (n < 8) st[n] = i;
        n++;
        prev = jx[0];
      end
      if (i == 60) raw[0] = 4'b0;
    end
    n_chk++;
    if (n !== 6) begin
      n_fail++; $display("FAIL repeat_count: got %0d expected 6", n);
    end
    for (int k = 0; k < 6; k++) begin
      if (k < n) begin
        n_chk++;
        if (st[k] !== exp_t[k]) begin
          n_fail++;
          $display("FAIL repeat_time_%0d: got %0d expected %0d", k, st[k], exp_t[k]);
        end
      end
    end
    n_chk++;
    if (jx[0] !== 10'd326) begin
      n_fail++; $display("FAIL repeat_x: got %0d expected 326", jx[0]);
    end
  endtask

  task automatic test_clamp_wrap();
    int mv_clamp = 0;
    int mv_wrap = 0;
    do_reset();
    raw[1] = 4'b0100;
    raw[2] = 4'b0100;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (mv[1]) mv_clamp++;
      if (mv[2]) mv_wrap++;
      if (i == 20) begin
        raw[1] = 4'b0;
        raw[2] = 4'b0;
      end
    end
    n_chk++;
    if (jx[1] !== 10'd639) begin
      n_fail++; $display("FAIL clamp_x: got %0d expected 639", jx[1]);
    end
    n_chk++;
    if (mv_clamp !== 0) begin
      n_fail++; $display("FAIL clamp_moved: got %0d pulses expected 0", mv_clamp);
    end
    n_chk++;
    if (jx[2] !== 10'd0) begin
      n_fail++; $display("FAIL wrap_x: got %0d expected 0", jx[2]);
    end
    n_chk++;
    if (mv_wrap !== 1) begin
      n_fail++; $display("FAIL wrap_moved: got %0d pulses expected 1", mv_wrap);
    end
  endtask

  task automatic test_conflict_diag();
    do_reset();
    raw[0] = 4'b1100;
    repeat (10) @(negedge clk);
    raw[0] = 4'b0;
    repeat (12) @(negedge clk);
    n_chk++;
    if (jx[0] !== 10'd320 || jy[0] !== 10'd240) begin
      n_fail++;
      $display("FAIL conflict_lr: got (%0d,%0d) expected (320,240)", jx[0], jy[0]);
    end
    do_reset();
    raw[0] = 4'b1010;
    raw[3] = 4'b1010;
    repeat (10) @(negedge clk);
    raw[0] = 4'b0;
    raw[3] = 4'b0;
    repeat (12) @(negedge clk);
    n_chk++;
    if (jx[0] !== 10'd319 || jy[0] !== 10'd240) begin
      n_fail++;
      $display("FAIL priority_ul: got (%0d,%0d) expected (319,240)", jx[0], jy[0]);
    end
    n_chk++;
    if (jx[3] !== 10'd319 || jy[3] !== 10'd239) begin
      n_fail++;
      $display("FAIL diagonal_ul: got (%0d,%0d) expected (319,239)", jx[3], jy[3]);
    end
  endtask

  task automatic test_frame_latch();
    do_reset();
    raw[0] = 4'b1000;
    repeat (6) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_chk++;
    if (jx[0] !== 10'd319) begin
      n_fail++; $display("FAIL frame_step_x: got %0d expected 319", jx[0]);
    end
    n_chk++;
    if (px[0] !== 10'd320) begin
      n_fail++; $display("FAIL frame_pre_step: got %0d expected 320", px[0]);
    end
    raw[0] = 4'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (px[0] !== 10'd320) begin
      n_fail++; $display("FAIL frame_hold: got %0d expected 320", px[0]);
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_chk++;
    if (px[0] !== 10'd319 || py[0] !== 10'd240) begin
      n_fail++;
      $display("FAIL frame_next_tick: got (%0d,%0d) expected (319,240)", px[0], py[0]);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) raw[i] = 4'b0;
    test_reset();
    test_glitch();
    test_single_press();
    test_auto_repeat();
    test_clamp_wrap();
    test_conflict_diag();
    test_frame_latch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
